switch_operand_sampler: RTL

- Input stage that sits directly upstream of the magnitude comparator.
- Synchronises and debounces the eight slide switches, then splits them into two 4-bit operands `a` (sw[3:0]) and `b` (sw[7:4]).
- Publishes operands only when the whole switch bank is settled, with a one-cycle `operand_valid` strobe on each change, so the comparator never sees bounce or a half-moved bank.

---
 rtl/sw_pkg.sv | 21 ++
 rtl/sw_debounce_bit.sv | 43 ++++
 rtl/switch_operand_sampler.sv | 100 ++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared constants and publish-state encoding for the switch operand sampler.
// Latency: none (types and constants only). Backpressure: n/a.
package sw_pkg;

  localparam int SW_WIDTH         = 8;
  localparam int OPERAND_W        = SW_WIDTH / 2;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PUBLISH = 2'd2
  } pub_state_t;

  // Published operand pair as it sits in the output register: b in the upper half.
  typedef struct packed {
    logic [OPERAND_W-1:0] b;
    logic [OPERAND_W-1:0] a;
  } operand_pair_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser then a mismatch counter guarding deb.
// Latency: DEBOUNCE_CYCLES+2 edges raw->deb. Backpressure: none, free-running.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic counting
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Any return-to-match clears the count, so only an unbroken run of
  // DEBOUNCE_CYCLES mismatching samples can move deb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      deb    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == deb) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb   <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign counting = (cnt_q != '0);

endmodule

// File: rtl/switch_operand_sampler.sv
// Debounces the switch bank and publishes {b,a} once the whole bank has settled.
// Latency: DEBOUNCE_CYCLES+5 edges raw->operand_valid. Backpressure: freeze holds publish.
module switch_operand_sampler
  import sw_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   sw_raw,
  input  logic               freeze,
  output logic [WIDTH/2-1:0] a,
  output logic [WIDTH/2-1:0] b,
  output logic               operand_valid,
  output logic               settled
);

  localparam int OPW = WIDTH / 2;

  logic [WIDTH-1:0] deb_bus;
  logic [WIDTH-1:0] counting_bus;
  logic [WIDTH-1:0] pub_q;
  logic             bank_diff;
  logic             load_pub;
  pub_state_t       state_q;
  pub_state_t       state_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (sw_raw[i]),
      .deb     (deb_bus[i]),
      .counting(counting_bus[i])
    );
  end

  assign bank_diff = (deb_bus != pub_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settled <= 1'b1;
    end else begin
      settled <= ~|counting_bus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A bank that bounces back to the published value drops out of ARMED
  // without a pulse, even while frozen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bank_diff) state_d = ARMED;
      ARMED: begin
        if (!bank_diff) begin
          state_d = IDLE;
        end else if (settled && !freeze) begin
          state_d = PUBLISH;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_pub = (state_q == PUBLISH);
  end

  // Operands and strobe are registered together so the comparator sees
  // the new pair on the same edge as operand_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pub_q         <= '0;
      operand_valid <= 1'b0;
    end else begin
      operand_valid <= load_pub;
      if (load_pub) begin
        pub_q <= deb_bus;
      end
    end
  end

  assign a = pub_q[OPW-1:0];
  assign b = pub_q[WIDTH-1:OPW];

endmodule
